// File: rtl/sorted_search.sv
// Lower-bound binary search over a K-entry register table, one probe per cycle.
// Define SORTED_SEARCH_ORDER_CHK_EN to flag table order violations on r_err.
module sorted_search #(
  parameter int N = 8,
  parameter int K = 10,
  localparam int W = $clog2(K + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         q_valid,
  output logic         q_ready,
  input  logic [N-1:0] q_key,
  output logic         r_valid,
  input  logic         r_ready,
  output logic         r_found,
  output logic [W-1:0] r_index,
  output logic         r_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [W-1:0] K_IDX = W'(K);
  localparam logic [W-1:0] ONE   = W'(1);

  state_t       state;
  logic [N-1:0] tbl [K];
  logic [N-1:0] key_q;
  logic [W-1:0] lo, hi;

  logic         wr_ok;
  logic         accept;
  logic [W:0]   sum;
  logic [W-1:0] mid, lo_next, hi_next;
  logic         hit_next;
  logic         order_err;

  assign q_ready = (state == IDLE);
  assign busy    = (state != IDLE);
  assign wr_ok   = wr_en && (state == IDLE) && (wr_addr < K_IDX);
  assign accept  = q_valid && (state == IDLE);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    sum      = {1'b0, lo} + {1'b0, hi};
    mid      = W'(sum >> 1);
    lo_next  = lo;
    hi_next  = hi;
    if (tbl[mid] < key_q) lo_next = mid + ONE;
    else                  hi_next = mid;
    hit_next = 1'b0;
    if (lo_next < K_IDX) hit_next = (tbl[lo_next] == key_q);
  end

`ifdef SORTED_SEARCH_ORDER_CHK_EN
  logic [N-1:0] post [K];

  // The check must see the table as it will be after a same-cycle write.
  always_comb begin
    order_err = 1'b0;
    for (int i = 0; i < K; i++)
      post[i] = (wr_ok && (wr_addr == W'(i))) ? wr_data : tbl[i];
    for (int i = 0; i < K - 1; i++)
      if (post[i] > post[i+1]) order_err = 1'b1;
  end
`else
  assign order_err = 1'b0;
`endif

  // NOTE: the table lives in flops and must read back as zero after reset, so it is reset here
  // rather than left uninitialised like a RAM would be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      lo      <= '0;
      hi      <= '0;
      r_valid <= 1'b0;
      r_found <= 1'b0;
      r_index <= '0;
      r_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_q <= q_key;
            lo    <= '0;
            hi    <= K_IDX;
            r_err <= order_err;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          lo <= lo_next;
          hi <= hi_next;
          if (lo_next == hi_next) begin
            r_index <= lo_next;
            r_found <= hit_next;
            r_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_search.sv
// Self-checking bench for sorted_search: directed cases plus randomized tables and keys
// compared against a linear-scan lower-bound model.
module tb_sorted_search;
  localparam int N = 8;
  localparam int K = 10;
  localparam int W = 4;
`ifdef SORTED_SEARCH_ORDER_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_addr = '0;
  logic [N-1:0] wr_data = '0;
  logic         q_valid = 1'b0;
  logic         q_ready;
  logic [N-1:0] q_key = '0;
  logic         r_valid;
  logic         r_ready = 1'b0;
  logic         r_found;
  logic [W-1:0] r_index;
  logic         r_err;
  logic         busy;

  sorted_search #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_valid(q_valid), .q_ready(q_ready), .q_key(q_key),
    .r_valid(r_valid), .r_ready(r_ready), .r_found(r_found),
    .r_index(r_index), .r_err(r_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] model [K];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lower_bound(input logic [N-1:0] key);
    for (int i = 0; i < K; i++) if (model[i] >= key) return i;
    return K;
  endfunction

  function automatic bit unsorted();
    for (int i = 0; i < K - 1; i++) if (model[i] > model[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  // Entered and left on a falling edge.
  task automatic write_entry(input int addr, input logic [N-1:0] data);
    wr_en = 1'b1; wr_addr = W'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < K) model[addr] = data;
  endtask

  task automatic load_table(input logic [N-1:0] vals [K]);
    for (int i = 0; i < K; i++) write_entry(i, vals[i]);
  endtask

  task automatic run_query(input string tag, input logic [N-1:0] key, input int hold,
                           input bit poke, input bit same_wr, input int sw_addr,
                           input logic [N-1:0] sw_data);
    int n, exp_idx;
    bit exp_found, exp_err, bad;
    logic [W-1:0] idx0;
    logic found0;
    check({tag, " q_ready"}, q_ready, 1'b1);
    q_valid = 1'b1; q_key = key;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = W'(sw_addr); wr_data = sw_data;
      if (sw_addr < K) model[sw_addr] = sw_data;
    end
    bad       = unsorted();
    exp_idx   = lower_bound(key);
    exp_found = (exp_idx < K) && (model[exp_idx] == key);
    exp_err   = CHK_EN && bad;
    @(negedge clk);
    q_valid = 1'b0; wr_en = 1'b0;
    n = 1;
    while (!r_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " r_valid"}, r_valid, 1'b1);
    check({tag, " latency<=5"}, (n <= 5), 1'b1);
    if (!bad) begin
      check({tag, " r_index"}, r_index, exp_idx);
      check({tag, " r_found"}, r_found, exp_found);
    end
    check({tag, " r_err"}, r_err, exp_err);
    check({tag, " busy"}, busy, 1'b1);
    idx0 = r_index; found0 = r_found;
    for (int c = 0; c < hold; c++) begin
      if (poke) begin
        wr_en = 1'b1; wr_addr = W'(c % K); wr_data = 8'hff;
      end
      @(negedge clk);
      wr_en = 1'b0;
      check({tag, " hold r_valid"}, r_valid, 1'b1);
      check({tag, " hold r_index"}, r_index, idx0);
      check({tag, " hold r_found"}, r_found, found0);
      check({tag, " hold r_err"}, r_err, exp_err);
      check({tag, " hold q_ready"}, q_ready, 1'b0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check({tag, " r_valid drop"}, r_valid, 1'b0);
    check({tag, " q_ready back"}, q_ready, 1'b1);
  endtask

  task automatic query(input string tag, input logic [N-1:0] key);
    run_query(tag, key, 0, 1'b0, 1'b0, 0, '0);
  endtask

  logic [N-1:0] ref_tbl [K];
  logic [N-1:0] rnd_tbl [K];

  initial begin
    for (int i = 0; i < K; i++) model[i] = '0;
    ref_tbl = '{8'h00, 8'h01, 8'h02, 8'h12, 8'h20, 8'h22, 8'h29, 8'h2a, 8'h42, 8'h52};

    repeat (3) @(negedge clk);
    check("rst r_valid", r_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst q_ready", q_ready, 1'b1);
    check("post-rst r_valid", r_valid, 1'b0);
    check("post-rst r_index", r_index, 0);
    check("post-rst r_found", r_found, 1'b0);
    check("post-rst r_err", r_err, 1'b0);
    check("post-rst busy", busy, 1'b0);

    load_table(ref_tbl);
    query("q29", 8'h29);
    check("q29 index literal", r_index, 6);
    query("q21", 8'h21);
    check("q21 index literal", r_index, 5);
    query("q00", 8'h00);
    query("q60", 8'h60);
    check("q60 index literal", r_index, K);
    query("q52", 8'h52);

    write_entry(12, 8'h07);
    query("oob write", 8'h07);

    // Long back-pressure with write pulses that must be dropped.
    run_query("hold", 8'h29, 8, 1'b1, 1'b0, 0, '0);
    query("hold readback", 8'h29);
    query("hold readback ff", 8'hff);

    // Same-cycle write and accept: the search sees the new value.
    run_query("samecyc", 8'h21, 1, 1'b0, 1'b1, 4, 8'h21);
    write_entry(4, 8'h20);

    write_entry(3, 8'h50);
    query("order", 8'h20);
    write_entry(3, 8'h12);
    query("order fixed", 8'h20);

    for (int it = 0; it < 40; it++) begin
      int acc;
      logic [N-1:0] key;
      if (it % 8 == 0) begin
        acc = $urandom_range(0, 10);
        for (int i = 0; i < K; i++) begin
          rnd_tbl[i] = (acc > 255) ? 8'hff : N'(acc);
          acc += $urandom_range(0, 30);
        end
        if ($urandom_range(0, 3) == 0) rnd_tbl[$urandom_range(0, K - 2)] = 8'hf0;
        load_table(rnd_tbl);
        write_entry($urandom_range(K, 15), N'($urandom));
      end
      if ($urandom_range(0, 1) == 1) key = model[$urandom_range(0, K - 1)];
      else                           key = N'($urandom_range(0, 255));
      if (!unsorted() && $urandom_range(0, 3) == 0) begin
        int a;
        int lo_v, hi_v;
        a    = $urandom_range(0, K - 1);
        lo_v = (a > 0) ? int'(model[a-1]) : 0;
        hi_v = (a < K - 1) ? int'(model[a+1]) : 255;
        run_query("rnd sw", key, $urandom_range(0, 2), 1'b0, 1'b1, a,
                  N'($urandom_range(lo_v, hi_v)));
      end else begin
        run_query("rnd", key, $urandom_range(0, 2), 1'b0, 1'b0, 0, '0);
      end
    end

    // Reset in the middle of a search aborts it and clears the table.
    load_table(ref_tbl);
    q_valid = 1'b1; q_key = 8'h29;
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < K; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort r_valid", r_valid, 1'b0);
    end
    check("abort q_ready", q_ready, 1'b1);
    check("abort busy idle", busy, 1'b0);
    check("abort r_index", r_index, 0);
    query("zero q00", 8'h00);
    query("zero q01", 8'h01);
    check("zero q01 index literal", r_index, K);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
